pc_nzp_unit: RTL

Parametrised per-thread program-counter and NZP-flag unit for a MiniGPU core, the successor of the single-thread PC/NZP block. It serves THREADS lanes at once. Each enabled lane latches NZP flags from its ALU result and computes its next PC. Beyond sequential and conditional-branch flow, it adds CALL/RET through a per-lane return-address stack, with sticky overflow/underflow error reporting. It sits between the ALU and the fetcher and is sequenced by the core scheduler's `core_state`.

---
 rtl/pc_nzp_unit_if.sv | 33 +++
 rtl/pc_nzp_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_nzp_unit_if.sv
// Bus bundle between the scheduler/ALU side and the per-lane PC/NZP unit.
// The master drives the control and per-lane operands. The slave returns the
// registered next PC, flags, valid pulse and sticky stack error per lane.
interface pc_nzp_unit_if #(
    parameter int THREADS    = 4,
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
);
    logic [2:0]                   core_state;
    logic [THREADS-1:0]           enable;
    logic [THREADS*DATA_WIDTH-1:0] alu_out;
    logic [THREADS*PC_WIDTH-1:0]  current_pc;
    logic                         nzp_write_enable;
    logic [1:0]                   pc_op;
    logic [2:0]                   nzp;
    logic [PC_WIDTH-1:0]          immediate;
    logic [THREADS*PC_WIDTH-1:0]  next_pc;
    logic [THREADS*3-1:0]         nzp_flags;
    logic [THREADS-1:0]           next_pc_valid;
    logic [THREADS-1:0]           stack_err;

    modport master (
        output core_state, enable, alu_out, current_pc,
               nzp_write_enable, pc_op, nzp, immediate,
        input  next_pc, nzp_flags, next_pc_valid, stack_err
    );

    modport slave (
        input  core_state, enable, alu_out, current_pc,
               nzp_write_enable, pc_op, nzp, immediate,
        output next_pc, nzp_flags, next_pc_valid, stack_err
    );
endinterface

// File: rtl/pc_nzp_unit.sv
// Per-lane program counter and NZP flag unit with a return-address stack.
// Each enabled lane in the UPDATE scheduler state latches flags, resolves
// SEQ/BR/CALL/RET and produces a registered next PC one cycle later.
// Stack overflow/underflow stalls the lane and sets a sticky error bit.
module pc_nzp_unit #(
    parameter int THREADS     = 4,
    parameter int PC_WIDTH    = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_nzp_unit_if.slave  bus
);

    localparam int         IDX_W        = $clog2(STACK_DEPTH);
    localparam int         SP_W         = IDX_W + 1;
    localparam logic [2:0] UPDATE_STATE = 3'b110;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_BR   = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } pc_op_e;

    // Architectural per-lane state
    logic [PC_WIDTH-1:0] next_pc_r [THREADS];
    logic [2:0]          flags_r   [THREADS];
    logic [PC_WIDTH-1:0] stack_r   [THREADS][STACK_DEPTH];
    logic [SP_W-1:0]     sp_r      [THREADS];
    logic [THREADS-1:0]  valid_r;
    logic [THREADS-1:0]  err_r;

    // Next-state values
    logic [PC_WIDTH-1:0] next_pc_s  [THREADS];
    logic [2:0]          flags_s    [THREADS];
    logic [SP_W-1:0]     sp_s       [THREADS];
    logic [SP_W-1:0]     sp_dec_s   [THREADS];
    logic [PC_WIDTH-1:0] cur_pc_s   [THREADS];
    logic [PC_WIDTH-1:0] pc_inc_s   [THREADS];
    logic [IDX_W-1:0]    top_idx_s  [THREADS];
    logic [IDX_W-1:0]    push_idx_s [THREADS];
    logic [THREADS-1:0]  valid_s;
    logic [THREADS-1:0]  err_s;
    logic [THREADS-1:0]  push_s;
    logic                update_s;
    pc_op_e              op_s;

    assign update_s = (bus.core_state == UPDATE_STATE);
    assign op_s     = pc_op_e'(bus.pc_op);

    // Per-lane flow resolution; branches test the flags held before this edge
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            cur_pc_s[t]   = bus.current_pc[t*PC_WIDTH +: PC_WIDTH];
            pc_inc_s[t]   = cur_pc_s[t] + PC_WIDTH'(1'b1);
            sp_dec_s[t]   = sp_r[t] - SP_W'(1'b1);
            top_idx_s[t]  = sp_dec_s[t][IDX_W-1:0];
            push_idx_s[t] = sp_r[t][IDX_W-1:0];
            next_pc_s[t]  = next_pc_r[t];
            flags_s[t]    = flags_r[t];
            sp_s[t]       = sp_r[t];
            valid_s[t]    = 1'b0;
            err_s[t]      = err_r[t];
            push_s[t]     = 1'b0;
            if (update_s && bus.enable[t]) begin
                valid_s[t] = 1'b1;
                if (bus.nzp_write_enable) begin
                    flags_s[t] = bus.alu_out[t*DATA_WIDTH +: 3];
                end else begin
                    flags_s[t] = flags_r[t];
                end
                case (op_s)
                    OP_SEQ: begin
                        next_pc_s[t] = pc_inc_s[t];
                    end
                    OP_BR: begin
                        if ((flags_r[t] & bus.nzp) != 3'b000) begin
                            next_pc_s[t] = bus.immediate;
                        end else begin
                            next_pc_s[t] = pc_inc_s[t];
                        end
                    end
                    OP_CALL: begin
                        if (sp_r[t] == SP_W'(STACK_DEPTH)) begin
                            // Full stack: stall the lane on its current PC
                            next_pc_s[t] = cur_pc_s[t];
                            err_s[t]     = 1'b1;
                        end else begin
                            push_s[t]    = 1'b1;
                            sp_s[t]      = sp_r[t] + SP_W'(1'b1);
                            next_pc_s[t] = bus.immediate;
                        end
                    end
                    OP_RET: begin
                        if (sp_r[t] == SP_W'(1'b0)) begin
                            // Empty stack: stall the lane on its current PC
                            next_pc_s[t] = cur_pc_s[t];
                            err_s[t]     = 1'b1;
                        end else begin
                            sp_s[t]      = sp_dec_s[t];
                            next_pc_s[t] = stack_r[t][top_idx_s[t]];
                        end
                    end
                    default: begin
                        next_pc_s[t] = pc_inc_s[t];
                    end
                endcase
            end else begin
                valid_s[t] = 1'b0;
            end
        end
    end

    // Per-lane state registers and return-stack writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {THREADS{1'b0}};
            err_r   <= {THREADS{1'b0}};
            for (int t = 0; t < THREADS; t++) begin
                next_pc_r[t] <= {PC_WIDTH{1'b0}};
                flags_r[t]   <= 3'b000;
                sp_r[t]      <= {SP_W{1'b0}};
                for (int d = 0; d < STACK_DEPTH; d++) begin
                    stack_r[t][d] <= {PC_WIDTH{1'b0}};
                end
            end
        end else begin
            valid_r <= valid_s;
            err_r   <= err_s;
            for (int t = 0; t < THREADS; t++) begin
                next_pc_r[t] <= next_pc_s[t];
                flags_r[t]   <= flags_s[t];
                sp_r[t]      <= sp_s[t];
                if (push_s[t]) begin
                    stack_r[t][push_idx_s[t]] <= pc_inc_s[t];
                end
            end
        end
    end

    for (genvar g = 0; g < THREADS; g++) begin : g_pack
        assign bus.next_pc[g*PC_WIDTH +: PC_WIDTH] = next_pc_r[g];
        assign bus.nzp_flags[g*3 +: 3]             = flags_r[g];
    end

    assign bus.next_pc_valid = valid_r;
    assign bus.stack_err     = err_r;

endmodule
